// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and stage-count derivation for the pipelined adder.
package adder_pkg;
    localparam int WIDTH_DEFAULT = 18;
    localparam int SEG_DEFAULT = 6;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    function automatic int stages(input int w, input int s);
        return (w / s < 1) ? 1 : w / s;
    endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: SEG-bit combinational ripple-carry full adder.
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = SEG_DEFAULT
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out
);
    logic [SEG:0] c;
    always_comb begin
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            sum[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[SEG];
    end
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: segmented add/subtract pipeline, one register stage per SEG bits,
// with a single global advance that stalls every stage while the output is blocked.
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SEG = SEG_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);
    localparam int STAGES = stages(WIDTH, SEG);
    if (WIDTH % SEG != 0) begin : bad_cfg
        $error("pipelined_adder_nbit: WIDTH must be a multiple of SEG");
    end
    logic adv;
    logic c0;
    logic [WIDTH-1:0] b_eff;
    always_comb begin
        out_valid = g[STAGES-1].v_q;
        sum = {g[STAGES-1].c_q, g[STAGES-1].r_q};
        adv = !out_valid || out_ready;
        in_ready = adv;
        b_eff = (sub == MODE_SUB) ? ~b : b;
        c0 = (sub == MODE_SUB) ? 1'b1 : c_in;
    end
    for (genvar k = 0; k < STAGES; k++) begin : g
        // operands shrink by one segment per stage; results grow by one segment
        localparam int RW = WIDTH - SEG * k;
        logic [RW-1:0] src_a, src_b;
        logic [SEG-1:0] seg_sum;
        logic seg_ci, c_d, c_q, v_d, v_q;
        logic [SEG*(k+1)-1:0] r_d, r_q;
        if (k == 0) begin : head
            always_comb begin
                src_a = a;
                src_b = b_eff;
                seg_ci = c0;
                v_d = in_valid;
                r_d = seg_sum;
            end
        end else begin : link
            always_comb begin
                src_a = g[k-1].op.a_q;
                src_b = g[k-1].op.b_q;
                seg_ci = g[k-1].c_q;
                v_d = g[k-1].v_q;
                r_d = {seg_sum, g[k-1].r_q};
            end
        end
        adder_segment #(.SEG(SEG)) u_seg (
            .a(src_a[SEG-1:0]),
            .b(src_b[SEG-1:0]),
            .c_in(seg_ci),
            .sum(seg_sum),
            .c_out(c_d)
        );
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= c_d;
                r_q <= r_d;
            end
        end
        if (k < STAGES - 1) begin : op
            logic [RW-SEG-1:0] a_d, b_d, a_q, b_q;
            always_comb begin
                a_d = src_a[RW-1:SEG];
                b_d = src_b[RW-1:SEG];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// tb_pipelined_adder_nbit: directed checks of latency, carry, subtract, streaming,
// backpressure, bubbles and mid-stream reset for the 18-bit, 3-stage configuration.
module tb_pipelined_adder_nbit;
    localparam int W = 18;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, c_in, sub, out_valid, out_ready;
    logic [W-1:0] a, b;
    logic [W:0] sum;
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] sa_v [100];
    logic [W-1:0] sb_v [100];
    logic sc_v [100];
    logic ss_v [100];

    always #5 clk = ~clk;

    pipelined_adder_nbit #(.WIDTH(W), .SEG(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
    );

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W-1:0] ny;
        ny = ~y;
        return s ? ({1'b0, x} + {1'b0, ny} + {{W{1'b0}}, 1'b1})
                 : ({1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci});
    endfunction

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        in_valid = v;
        a = x;
        b = y;
        c_in = ci;
        sub = s;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(0, '0, '0, 0, 0);
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        drive(1, 18'h3FFFF, 18'h00001, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        check("lat_c1_valid", out_valid, 0);
        step();
        check("lat_c2_valid", out_valid, 0);
        step();
        check("carry_valid", out_valid, 1);
        check("carry_sum", sum, 19'h40000);
        step();
        check("carry_drain", out_valid, 0);

        drive(1, 18'h00000, 18'h00000, 1, 0);
        step();
        drive(1, 18'h00005, 18'h00007, 1, 1);
        step();
        drive(1, 18'h00007, 18'h00005, 0, 1);
        step();
        drive(0, '0, '0, 0, 0);
        check("cin_only", sum, 19'h00001);
        step();
        check("sub_borrow", sum, 19'h3FFFE);
        step();
        check("sub_noborrow", sum, 19'h40002);
        step();

        for (int j = 0; j < 100; j++) begin
            sa_v[j] = W'(j * 32'h0A3B7 + 32'h1F00F);
            sb_v[j] = W'((j * 32'h1C2D5) ^ 32'h3FFF0);
            sc_v[j] = j[0];
            ss_v[j] = (j % 3) == 0;
        end
        for (int j = 0; j < 102; j++) begin
            if (j < 100) begin
                drive(1, sa_v[j], sb_v[j], sc_v[j], ss_v[j]);
                check("stream_in_ready", in_ready, 1);
            end else begin
                drive(0, '0, '0, 0, 0);
            end
            step();
            if (j >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_sum", sum, model(sa_v[j-2], sb_v[j-2], sc_v[j-2], ss_v[j-2]));
            end
        end
        drive(0, '0, '0, 0, 0);
        step();
        check("stream_drain", out_valid, 0);

        drive(1, 18'h12345, 18'h11111, 0, 0);
        step();
        drive(1, 18'h3FFFF, 18'h3FFFF, 1, 0);
        step();
        drive(1, 18'h00000, 18'h00001, 0, 1);
        step();
        drive(1, 18'h20000, 18'h20000, 0, 0);
        out_ready = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold", sum, 19'h23456);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        drive(0, '0, '0, 0, 0);
        check("bp_r1", sum, 19'h7FFFF);
        step();
        check("bp_r2", sum, 19'h3FFFF);
        step();
        check("bp_r3_valid", out_valid, 1);
        check("bp_r3", sum, 19'h40000);
        step();
        check("bp_drain", out_valid, 0);

        out_ready = 1'b0;
        #1;
        check("idle_no_block", in_ready, 1);
        drive(1, 18'h00001, 18'h00002, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        step();
        step();
        check("noready_valid", out_valid, 1);
        check("noready_sum", sum, 19'h00003);
        check("noready_stall", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("noready_drain", out_valid, 0);

        drive(1, 18'h00100, 18'h00200, 0, 0);
        step();
        drive(0, 18'h3FFFF, 18'h3FFFF, 1, 0);
        step();
        drive(1, 18'h00AAA, 18'h00555, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        check("bub_v1", out_valid, 1);
        check("bub_s1", sum, 19'h00300);
        step();
        check("bub_v0", out_valid, 0);
        step();
        check("bub_v2", out_valid, 1);
        check("bub_s2", sum, 19'h00FFF);
        step();

        drive(1, 18'h11111, 18'h22222, 0, 0);
        step();
        drive(1, 18'h01010, 18'h02020, 0, 0);
        step();
        drive(1, 18'h3F000, 18'h01000, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        check("rstmid_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_sum", sum, 0);
        step();
        reset = 1'b0;
        drive(1, 18'h00010, 18'h00020, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        check("post_rst_c1", out_valid, 0);
        step();
        check("post_rst_c2", out_valid, 0);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_sum", sum, 19'h00030);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
